// File: rtl/fifo_burst_reader.sv
// Read-domain drain engine: pops the FIFO in fixed-length bursts onto a valid/ready stream.
// Optional partial-burst flush on idle timeout when FIFO_BURST_READER_TIMEOUT_EN is defined.
module fifo_burst_reader #(
  parameter int DATA_WIDTH       = 8,
  parameter int FIFO_DEPTH_WIDTH = 11,
  parameter int BURST_LEN        = 16,
  parameter int TIMEOUT          = 255
) (
  input  logic                        clk_read,
  input  logic                        rst,
  input  logic                        fifo_empty,
  input  logic [FIFO_DEPTH_WIDTH-1:0] fifo_count,
  input  logic [DATA_WIDTH-1:0]       fifo_data,
  output logic                        fifo_read,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_last,
  output logic                        busy,
  output logic [15:0]                 burst_count
);

  localparam int CW = FIFO_DEPTH_WIDTH + 1;
  localparam logic [CW-1:0] BURST_LEN_C = CW'(BURST_LEN);

  if (BURST_LEN < 1 || BURST_LEN > (1 << FIFO_DEPTH_WIDTH)) begin : g_bad_burst_len
    $error("fifo_burst_reader: BURST_LEN out of range");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("fifo_burst_reader: TIMEOUT out of range");
  end

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state, state_next;
  logic [CW-1:0]         beat, len, start_len, eff_count;
  logic [1:0]            occ;
  logic [DATA_WIDTH:0]   skid0, skid1;
  logic                  start, last_beat, pop_out;

  // A zero count with a non-empty FIFO means the count field wrapped at full.
  always_comb begin
    eff_count = {1'b0, fifo_count};
    if (fifo_count == '0 && !fifo_empty)
      eff_count = {1'b1, {FIFO_DEPTH_WIDTH{1'b0}}};
  end

  assign last_beat = (beat == len - CW'(1));
  assign fifo_read = !rst && (state == BURST) && !fifo_empty && (occ <= 2'd1);
  assign pop_out   = (occ != 2'd0) && m_ready;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  logic [15:0] idle_timer;
  logic        timed_out;

  assign timed_out = (idle_timer >= 16'(TIMEOUT)) && !fifo_empty && (eff_count != '0);

  always_ff @(posedge clk_read or posedge rst) begin
    if (rst)
      idle_timer <= '0;
    else if (fifo_empty || start)
      idle_timer <= '0;
    else if (state == IDLE && eff_count < BURST_LEN_C && idle_timer != 16'hFFFF)
      idle_timer <= idle_timer + 16'd1;
  end
`else
  logic timed_out;
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_next = state;
    start      = 1'b0;
    start_len  = BURST_LEN_C;
    case (state)
      IDLE: begin
        if (eff_count >= BURST_LEN_C) begin
          start = 1'b1;
        end else if (timed_out) begin
          start     = 1'b1;
          start_len = eff_count;
        end
        if (start)
          state_next = BURST;
      end
      BURST: begin
        if (fifo_read && last_beat)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_read or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
      len   <= BURST_LEN_C;
    end else begin
      state <= state_next;
      if (start) begin
        beat <= '0;
        len  <= start_len;
      end else if (fifo_read) begin
        beat <= beat + CW'(1);
      end
    end
  end

  // Two-entry skid buffer; a new word queues behind the head on a simultaneous push/pop.
  always_ff @(posedge clk_read or posedge rst) begin
    if (rst) begin
      occ   <= '0;
      skid0 <= '0;
      skid1 <= '0;
    end else begin
      case ({fifo_read, pop_out})
        2'b10: begin
          if (occ == 2'd0) skid0 <= {last_beat, fifo_data};
          else             skid1 <= {last_beat, fifo_data};
          occ <= occ + 2'd1;
        end
        2'b01: begin
          skid0 <= skid1;
          occ   <= occ - 2'd1;
        end
        2'b11: skid0 <= {last_beat, fifo_data};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_read or posedge rst) begin
    if (rst)
      burst_count <= '0;
    else if (pop_out && skid0[DATA_WIDTH])
      burst_count <= burst_count + 16'd1;
  end

  assign m_valid = (occ != 2'd0);
  assign m_data  = skid0[DATA_WIDTH-1:0];
  assign m_last  = m_valid && skid0[DATA_WIDTH];
  assign busy    = (state == BURST) || (occ != 2'd0);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural FWFT FIFO model (BURST_LEN=4).
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk_read = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [AW-1:0] fifo_count = '0;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_read;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic [15:0]   burst_count;

  fifo_burst_reader #(
    .DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(AW), .BURST_LEN(4), .TIMEOUT(10)
  ) dut (
    .clk_read(clk_read), .rst(rst), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .fifo_data(fifo_data), .fifo_read(fifo_read), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .burst_count(burst_count)
  );

  always #5 clk_read = ~clk_read;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int pops = 0;
  int pops_seen = 0;
  logic force_empty = 1'b0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] got_d[$];
  logic          got_l[$];
  int            pop_cyc[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Handshake monitor: records pops and accepted beats at the active edge.
  always @(posedge clk_read) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (fifo_read) begin
        pops <= pops + 1;
        pop_cyc.push_back(cyc);
      end
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
      end
    end
  end

  // FWFT FIFO model: applies pops and refreshes its flags away from the active edge.
  always @(negedge clk_read) begin
    if (pops_seen != pops) begin
      void'(q.pop_front());
      pops_seen <= pops;
    end
    fifo_empty <= force_empty || (q.size() == 0);
    fifo_count <= AW'(q.size());
    fifo_data  <= (q.size() != 0) ? q[0] : '0;
  end

  task automatic push_words(input int first, input int n);
    for (int i = 0; i < n; i++) q.push_back(DW'(first + i));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_read);
  endtask

  task automatic wait_bursts(input int target, input int budget);
    int k = 0;
    while (burst_count != 16'(target) && k < budget) begin
      @(negedge clk_read);
      k++;
    end
    check("burst_wait", burst_count, target);
  endtask

  task automatic check_beats(input string tag, input int first, input int n);
    check({tag, "_nbeats"}, got_d.size(), n);
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      check({tag, "_data"}, got_d[i], DW'(first + i));
      check({tag, "_last"}, got_l[i], (i == n - 1));
    end
    got_d.delete();
    got_l.delete();
  endtask

  initial begin
    int base, p2;
    cycles(3);
    check("rst_valid", m_valid, 0);
    check("rst_read", fifo_read, 0);
    check("rst_busy", busy, 0);
    check("rst_bcount", burst_count, 0);
    rst = 1'b0;
    cycles(2);

    // Full burst with m_ready held high
    m_ready = 1'b1;
    pop_cyc.delete();
    push_words('h11, 4);
    wait_bursts(1, 50);
    check_beats("b1", 'h11, 4);
    check("b1_pops", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4) check("b1_back2back", pop_cyc[3] - pop_cyc[0], 3);
    cycles(2);
    check("b1_idle_busy", busy, 0);

`ifndef FIFO_BURST_READER_TIMEOUT_EN
    // Residual words below BURST_LEN stay put
    base = pops;
    push_words('h21, 3);
    cycles(1000);
    check("resid_pops", pops - base, 0);
    push_words('h24, 1);
    wait_bursts(2, 50);
    check_beats("b2", 'h21, 4);
`else
    push_words('h21, 4);
    wait_bursts(2, 50);
    check_beats("b2", 'h21, 4);
`endif

    // Downstream back-pressure: skid buffer fills then popping stops
    m_ready = 1'b0;
    base = pops;
    push_words('h31, 4);
    cycles(20);
    check("bp_pops", pops - base, 2);
    check("bp_read", fifo_read, 0);
    check("bp_valid", m_valid, 1);
    check("bp_data", m_data, 'h31);
    check("bp_last", m_last, 0);
    m_ready = 1'b1;
    wait_bursts(3, 50);
    check_beats("b3", 'h31, 4);

    // FIFO goes empty mid-burst
    base = pops;
    push_words('h41, 4);
    for (int k = 0; k < 40 && pops - base < 2; k++) @(negedge clk_read);
    force_empty = 1'b1;
    cycles(2);
    p2 = pops;
    cycles(3);
    check("stall_pops", pops, p2);
    check("stall_partial", (pops - base) < 4, 1);
    check("stall_busy", busy, 1);
    force_empty = 1'b0;
    wait_bursts(4, 50);
    check_beats("b4", 'h41, 4);

    // Reset mid-burst with two buffered words
    m_ready = 1'b0;
    base = pops;
    push_words('h51, 4);
    cycles(10);
    check("pre_rst_pops", pops - base, 2);
    rst = 1'b1;
    #1;
    check("mr_read", fifo_read, 0);
    check("mr_valid", m_valid, 0);
    check("mr_last", m_last, 0);
    check("mr_data", m_data, 0);
    check("mr_busy", busy, 0);
    check("mr_bcount", burst_count, 0);
    cycles(2);
    rst = 1'b0;
    got_d.delete();
    got_l.delete();
    m_ready = 1'b1;
    push_words('h55, 2);
    wait_bursts(1, 50);
    check_beats("b5", 'h53, 4);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    // Partial burst after idle timeout
    cycles(5);
    pop_cyc.delete();
    base = cyc;
    push_words('h61, 2);
    wait_bursts(2, 60);
    check_beats("to", 'h61, 2);
    check("to_pops", pop_cyc.size(), 2);
    if (pop_cyc.size() != 0)
      check("to_latency", (pop_cyc[0] - base >= 11) && (pop_cyc[0] - base <= 13), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
